turn_lever_decoder: RTL and testbench

- Upstream input stage for the turn-signal sequencer (`turn`).
- Converts raw, asynchronous, bouncy lever and hazard-button inputs into the clean 2-bit direction code D consumed by the sequencer: 00 straight, 01 right, 10 left, 11 hazard.
- Provides synchronisation, debounce, a hazard toggle latch, a left/right conflict rule and a turn auto-cancel timeout.

---
 rtl/turn_pkg.sv | 19 +
 rtl/turn_lever_decoder_sync_debounce.sv | 46 ++++
 rtl/turn_lever_decoder.sv | 79 +++++++
 tb/tb_turn_lever_decoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/turn_pkg.sv
// rtl/turn_pkg.sv - direction codes shared by the turn-signal decoder, sequencer and benches
package turn_pkg;

    localparam logic [1:0] DIR_STRAIGHT = 2'b00;
    localparam logic [1:0] DIR_RIGHT    = 2'b01;
    localparam logic [1:0] DIR_LEFT     = 2'b10;
    localparam logic [1:0] DIR_HAZARD   = 2'b11;

    // Both levers closed at once is a contact fault and reads as neutral.
    function automatic logic [1:0] lever_code(input logic left, input logic right);
        if (left && !right)
            return DIR_LEFT;
        else if (right && !left)
            return DIR_RIGHT;
        else
            return DIR_STRAIGHT;
    endfunction

endpackage

// File: rtl/turn_lever_decoder_sync_debounce.sv
// rtl/turn_lever_decoder_sync_debounce.sv - 2-flop synchroniser plus stable-count debounce for one raw contact
module sync_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw_i,
    output logic level_o
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Level flips on the edge the count would reach DB_CYCLES, so the counter never holds that value.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (s2_q != level_q) begin
            if (cnt_q == DB_LAST)
                level_d = ~level_q;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/turn_lever_decoder.sv
// rtl/turn_lever_decoder.sv - lever/hazard input stage producing the clean direction code for the sequencer
module turn_lever_decoder
    import turn_pkg::*;
#(
    parameter int DB_CYCLES  = 4,
    parameter int TMO_CYCLES = 64,
    parameter bit TMO_EN     = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LEFT_SW,
    input  logic       RIGHT_SW,
    input  logic       HAZ_BTN,
    output logic [1:0] D,
    output logic       HAZ_ON,
    output logic       CANCELLED
);

    localparam int TW = $clog2(TMO_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TMO_CYCLES);

    logic          left_lvl, right_lvl, haz_lvl;
    logic          haz_prev_q, haz_on_q, haz_on_d;
    logic          cancel_q, cancel_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    d_q, d_d, lever;
    logic          neutral;

    sync_debounce #(.DB_CYCLES(DB_CYCLES)) u_left (
        .CLK(CLK), .RST(RST), .raw_i(LEFT_SW), .level_o(left_lvl)
    );
    sync_debounce #(.DB_CYCLES(DB_CYCLES)) u_right (
        .CLK(CLK), .RST(RST), .raw_i(RIGHT_SW), .level_o(right_lvl)
    );
    sync_debounce #(.DB_CYCLES(DB_CYCLES)) u_haz (
        .CLK(CLK), .RST(RST), .raw_i(HAZ_BTN), .level_o(haz_lvl)
    );

    // Next-state hazard and cancel values feed the decode so D, HAZ_ON and CANCELLED move on the same edge.
    always_comb begin
        haz_on_d = haz_on_q ^ (haz_lvl & ~haz_prev_q);
        lever    = lever_code(left_lvl, right_lvl);
        neutral  = ~left_lvl & ~right_lvl;
        tmo_d    = '0;
        cancel_d = 1'b0;
        if (TMO_EN) begin
            if (!haz_on_d && lever != DIR_STRAIGHT && d_q == lever)
                tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
            cancel_d = cancel_q ? ~neutral : (tmo_d == TMO_MAX);
        end
        if (haz_on_d)
            d_d = DIR_HAZARD;
        else if (cancel_d)
            d_d = DIR_STRAIGHT;
        else
            d_d = lever;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            haz_prev_q <= 1'b0;
            haz_on_q   <= 1'b0;
            cancel_q   <= 1'b0;
            tmo_q      <= '0;
            d_q        <= DIR_STRAIGHT;
        end else begin
            haz_prev_q <= haz_lvl;
            haz_on_q   <= haz_on_d;
            cancel_q   <= cancel_d;
            tmo_q      <= tmo_d;
            d_q        <= d_d;
        end
    end

    assign D         = d_q;
    assign HAZ_ON    = haz_on_q;
    assign CANCELLED = cancel_q;

endmodule

// File: tb/tb_turn_lever_decoder.sv
// tb/tb_turn_lever_decoder.sv - directed tables, corner sequences and random stimulus against a reference model
module tb_turn_lever_decoder;

    localparam int DB = 4;

    logic       clk, rst, lsw, rsw, hbtn;
    logic [1:0] dd[3];
    logic       hh[3], cc[3];
    int         checks = 0;
    int         errors = 0;

    turn_lever_decoder #(.DB_CYCLES(DB), .TMO_CYCLES(64), .TMO_EN(1'b1)) u_a (
        .CLK(clk), .RST(rst), .LEFT_SW(lsw), .RIGHT_SW(rsw), .HAZ_BTN(hbtn),
        .D(dd[0]), .HAZ_ON(hh[0]), .CANCELLED(cc[0]));
    turn_lever_decoder #(.DB_CYCLES(DB), .TMO_CYCLES(8), .TMO_EN(1'b1)) u_b (
        .CLK(clk), .RST(rst), .LEFT_SW(lsw), .RIGHT_SW(rsw), .HAZ_BTN(hbtn),
        .D(dd[1]), .HAZ_ON(hh[1]), .CANCELLED(cc[1]));
    turn_lever_decoder #(.DB_CYCLES(DB), .TMO_CYCLES(8), .TMO_EN(1'b0)) u_c (
        .CLK(clk), .RST(rst), .LEFT_SW(lsw), .RIGHT_SW(rsw), .HAZ_BTN(hbtn),
        .D(dd[2]), .HAZ_ON(hh[2]), .CANCELLED(cc[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; lsw = 1'b0; rsw = 1'b0; hbtn = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    function automatic int outs(input int i);
        return {dd[i], hh[i], cc[i]};
    endfunction

    // Reference model: lever levels accepted after DB identical synchronised samples,
    // hazard toggles on level rise, turn cancelled once shown for TMO consecutive cycles.
    int          tmo_p[3] = '{64, 8, 8};
    bit          en_p[3]  = '{1'b1, 1'b1, 1'b0};
    logic [2:0]  ms1, ms2, mlvl;
    logic        mhprev, mhaz;
    logic        hist[3][DB];
    int          hn[3];
    int          streak[3];
    logic        mcanc[3];
    logic [1:0]  md[3];

    always @(posedge clk) begin : model
        logic [1:0] raw;
        logic       rise, smp, all_diff;
        if (!rst) begin
            ms1 = '0; ms2 = '0; mlvl = '0; mhprev = 1'b0; mhaz = 1'b0;
            for (int i = 0; i < 3; i++) begin
                hn[i] = 0; streak[i] = 0; mcanc[i] = 1'b0; md[i] = 2'b00;
                for (int j = 0; j < DB; j++) hist[i][j] = 1'b0;
            end
        end else begin
            rise   = mlvl[2] & ~mhprev;
            mhprev = mlvl[2];
            mhaz   = mhaz ^ rise;
            raw = (mlvl[0] && !mlvl[1]) ? 2'b10 : (mlvl[1] && !mlvl[0]) ? 2'b01 : 2'b00;
            for (int i = 0; i < 3; i++) begin
                if (raw != 2'b00 && md[i] == raw && !mhaz)
                    streak[i] = (streak[i] < tmo_p[i]) ? streak[i] + 1 : streak[i];
                else
                    streak[i] = 0;
                if (!en_p[i] || mlvl[1:0] == 2'b00) mcanc[i] = 1'b0;
                else if (streak[i] == tmo_p[i])     mcanc[i] = 1'b1;
                md[i] = mhaz ? 2'b11 : (mcanc[i] ? 2'b00 : raw);
            end
            for (int c = 0; c < 3; c++) begin
                smp = ms2[c];
                for (int j = DB - 1; j > 0; j--) hist[c][j] = hist[c][j-1];
                hist[c][0] = smp;
                if (hn[c] < DB) hn[c]++;
                all_diff = (hn[c] == DB);
                for (int j = 0; j < DB; j++) if (hist[c][j] == mlvl[c]) all_diff = 1'b0;
                if (all_diff) mlvl[c] = ~mlvl[c];
            end
            ms2 = ms1;
            ms1 = {hbtn, rsw, lsw};
        end
    end

    typedef struct {
        logic       l, r, h;
        int         cyc;
        logic [1:0] d;
        logic       hz, cn;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int n01, bad;
        rst = 1'b0; lsw = 1'b0; rsw = 1'b0; hbtn = 1'b0;

        tbl[0]  = '{0, 0, 0,  4, 2'b00, 0, 0};
        tbl[1]  = '{1, 0, 0,  3, 2'b00, 0, 0};
        tbl[2]  = '{0, 0, 0, 10, 2'b00, 0, 0};
        tbl[3]  = '{1, 0, 0, 10, 2'b10, 0, 0};
        tbl[4]  = '{0, 0, 0, 10, 2'b00, 0, 0};
        tbl[5]  = '{0, 0, 1, 10, 2'b11, 1, 0};
        tbl[6]  = '{0, 0, 0, 10, 2'b11, 1, 0};
        tbl[7]  = '{0, 1, 0, 10, 2'b11, 1, 0};
        tbl[8]  = '{0, 1, 1, 10, 2'b01, 0, 0};
        tbl[9]  = '{0, 1, 0, 10, 2'b01, 0, 0};
        tbl[10] = '{0, 0, 0, 10, 2'b00, 0, 0};
        tbl[11] = '{1, 1, 0, 10, 2'b00, 0, 0};
        tbl[12] = '{1, 0, 0, 10, 2'b10, 0, 0};
        tbl[13] = '{0, 0, 0, 10, 2'b00, 0, 0};

        // Reset and idle
        tick(2);
        chk("reset_state", outs(0), 0);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (outs(0) != 0) bad++;
        end
        chk("idle_after_reset", bad, 0);

        // Exact lever latency, then asynchronous reset mid-turn
        lsw = 1'b1;
        tick(6);
        chk("latency_not_early", dd[0], 2'b00);
        tick(1);
        chk("latency_exact", dd[0], 2'b10);
        #2 rst = 1'b0;
        #1 chk("async_reset_mid_turn", outs(0), 0);
        lsw = 1'b0;
        tick(1);
        rst = 1'b1;

        do_reset();
        for (int v = 0; v < 14; v++) begin
            lsw = tbl[v].l; rsw = tbl[v].r; hbtn = tbl[v].h;
            tick(tbl[v].cyc);
            chk($sformatf("table_%0d", v), outs(0), {tbl[v].d, tbl[v].hz, tbl[v].cn});
        end

        // One-cycle dropouts every three cycles must not release the lever
        lsw = 1'b1;
        tick(10);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            lsw = 1'b0; tick(1); if (dd[0] != 2'b10) bad++;
            lsw = 1'b1; tick(2); if (dd[0] != 2'b10) bad++;
        end
        chk("dropout_hold", bad, 0);

        // Auto-cancel with an 8-cycle timeout
        do_reset();
        rsw = 1'b1;
        n01 = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (dd[1] == 2'b01) n01++;
            else if (n01 > 0) break;
        end
        chk("tmo_right_cycles", n01, 8);
        chk("tmo_cancelled", outs(1), {2'b00, 1'b0, 1'b1});
        rsw = 1'b0; lsw = 1'b1;
        tick(15);
        chk("tmo_swap_stays_cancelled", outs(1), {2'b00, 1'b0, 1'b1});
        lsw = 1'b0;
        tick(10);
        chk("tmo_neutral_clears", outs(1), 0);
        lsw = 1'b1;
        tick(8);
        chk("tmo_left_again", outs(1), {2'b10, 1'b0, 1'b0});

        // Timeout disabled: left held well past the timeout
        do_reset();
        lsw = 1'b1;
        tick(8);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (dd[2] != 2'b10 || cc[2] != 1'b0) bad++;
        end
        chk("tmo_disabled_hold", bad, 0);
        chk("tmo_enabled_contrast", cc[1], 1);

        // Randomised segments compared against the model on all three instances
        do_reset();
        for (int s = 0; s < 300; s++) begin
            int dur;
            lsw  = ($urandom_range(0, 2) == 0);
            rsw  = ($urandom_range(0, 2) == 0);
            hbtn = ($urandom_range(0, 4) == 0);
            dur  = ($urandom_range(0, 9) == 0) ? 80 : $urandom_range(1, 12);
            for (int c = 0; c < dur; c++) begin
                tick(1);
                for (int i = 0; i < 3; i++)
                    chk($sformatf("rand_dut%0d_seg%0d", i, s), outs(i), {md[i], mhaz, mcanc[i]});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
